fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single 128-bit FIFO write port among NUM_REQ producers. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst, throttles on the FIFO's almost-full flag, and drives the FIFO write enable and data from registers. It sits directly in front of the FIFO's i_wren/i_wdata inputs and consumes its o_full/o_alm_full outputs.

## Interface
- NUM_REQ, 4, number of producers (2..16)
- DATA_W, 128, data width; equals the FIFO word width
- MAX_BURST, 8, maximum beats per grant (≥1)
- clk  input  1  clock; all logic on posedge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-producer beat valid
- req_data  input  NUM_REQ*DATA_W  per-producer data; producer i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  per-producer accept, combinational
- fifo_full  input  1  FIFO o_full
- fifo_alm_full  input  1  FIFO o_alm_full
- fifo_wren  output  1  FIFO i_wren, registered
- fifo_wdata  output  DATA_W  FIFO i_wdata, registered
- grant_vld  output  1  high while in BURST
- grant_id  output  $clog2(NUM_REQ)  current or last granted producer

## Operation
- FSM has two states: IDLE and BURST.
- IDLE:
  - If any req_valid is high, pick the first valid producer searching upward, with wrap-around, from last_grant+1.
  - Load grant_id and last_grant with that producer, clear beat_cnt, and go to BURST.
  - IDLE never accepts a beat, so each grant costs one arbitration bubble.
- BURST:
  - req_ready[grant_id] = !fifo_alm_full && !fifo_full. All other req_ready bits are 0.
  - Accept = req_valid[grant_id] && req_ready[grant_id]. On accept, beat_cnt increments.
  - Exit to IDLE on an accept with beat_cnt == MAX_BURST-1.
  - Also exit to IDLE in any cycle where req_valid[grant_id] == 0, including while stalled.
  - While fifo_alm_full or fifo_full is high: no accept, beat_cnt holds, state stays in BURST (subject to the valid-drop exit).
- MAX_BURST = 1: every accepted beat returns to IDLE, giving strict per-beat round-robin.
- Fairness: last_grant updates only on the IDLE→BURST transition. A producer that is continuously valid waits at most (NUM_REQ-1) bursts.
- Headroom: the FIFO almost-full threshold must leave ≥2 free entries. This covers the one registered beat in flight plus the flag latency. fifo_full gating is a backstop only.
- beat_cnt width is $clog2(MAX_BURST+1). No wrap is possible because BURST exits at MAX_BURST-1.

## Timing
- Write latency: an accept in cycle t produces fifo_wren=1 with fifo_wdata = that beat in cycle t+1.
- fifo_wren = 0 in every cycle after a non-accept cycle. fifo_wdata holds its last value when fifo_wren = 0.
- Reset values: state IDLE, fifo_wren 0, fifo_wdata 0, grant_vld 0, grant_id 0, last_grant NUM_REQ-1 (so producer 0 wins first), beat_cnt 0, req_ready all 0.
- Reset asserted mid-burst: all state clears asynchronously, and a pending fifo_wren is dropped in the same cycle. The beat accepted in the previous cycle is lost; producers must treat reset as a stream flush.
- Simultaneous requests in IDLE: round-robin order only; there is no fixed priority.
- Almost-full rising in the same cycle as an accept attempt: req_ready is already low, so no accept occurs.
- Valid-drop and almost-full in the same BURST cycle: exit to IDLE.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST)
  - the DATA_W default
  - localparams for grant_id and beat_cnt widths
- Sub-module rr_picker, combinational:
  - inputs: request vector, last_grant
  - outputs: pick_vld, pick_id
  - rotate, find-first, un-rotate
- The top level contains the FSM, the counters, and the output registers.

## Test plan
- Single producer: req_valid=4'b0001 with 20 beats, MAX_BURST=8.
  - Required: bursts of 8, 8, 4 beats, one idle cycle between bursts.
  - fifo_wdata sequence equals the input sequence, one-cycle delayed.
- All four producers continuously valid, MAX_BURST=2.
  - Required grant order: 0,1,2,3,0,…, two beats each, each beat tagged with its producer ID in the data.
- fifo_alm_full forced high for 5 cycles mid-burst.
  - Required: req_ready low and fifo_wren 0 during the stall, beat_cnt held.
  - The burst resumes and completes the remaining beats with no loss or duplication.
- Producer 2 drops valid after 3 of 8 beats while producer 3 is valid.
  - Required: IDLE for one cycle, then grant_id=3.
- Reset asserted for 2 cycles during a burst.
  - Required: fifo_wren 0 immediately and all outputs at reset values.
  - After release, the first grant goes to the lowest valid producer (producer 0 if valid).

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-side arbiter:
//   - arb_state_e    : arbiter FSM states (IDLE, BURST)
//   - DATA_W_DEF     : default data width (one FIFO word)
//   - grant_id_width : width of grant_id / last_grant for a producer count
//   - beat_cnt_width : width of the per-burst beat counter for a burst limit
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DATA_W_DEF = 128;

  function automatic int grant_id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Counter must be able to represent MAX_BURST-1; the +1 keeps MAX_BURST=1
  // at a legal one-bit width.
  function automatic int beat_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches the request vector upward from
// last_grant+1 (wrapping) and returns the first requester found.
// Ports:
//   req_i        : request vector, one bit per producer
//   last_grant_i : most recently granted producer
//   pick_vld_o   : at least one request is present
//   pick_id_o    : selected producer index
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic               pick_vld_o,
  output logic [ID_W-1:0]    pick_id_o
);

  localparam logic [ID_W:0] LAST_IDX  = (ID_W+1)'(NUM_REQ - 1);
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]          start;
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [NUM_REQ-1:0]     rot;
  logic [ID_W:0]          offset;
  logic [ID_W:0]          sum;

  always_comb begin
    // Search origin is last_grant+1 modulo NUM_REQ.
    if ({1'b0, last_grant_i} >= LAST_IDX) begin
      start = '0;
    end else begin
      start = {1'b0, last_grant_i} + 1'b1;
    end

    // Rotate so the search origin lands at bit 0; the doubled vector makes
    // the wrap-around a plain part-select.
    req_dbl = {req_i, req_i};
    rot     = req_dbl[start +: NUM_REQ];

    // Find-first from bit 0 (descending loop leaves the lowest hit).
    pick_vld_o = |rot;
    offset     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = (ID_W+1)'(k);
      end
    end

    // Un-rotate back to a producer index.
    sum = start + offset;
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end
    pick_id_o = sum[ID_W-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready
// producers. A grant lasts for up to MAX_BURST beats, is throttled by the
// FIFO almost-full/full flags, and ends early when the granted producer drops
// valid. FIFO write enable and data are driven from registers.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   req_valid/req_data   : producer streams (producer i at [i*DATA_W +: DATA_W])
//   req_ready            : combinational accept, only for the granted producer
//   fifo_full/alm_full   : FIFO status flags
//   fifo_wren/fifo_wdata : registered FIFO write interface
//   grant_vld/grant_id   : burst active / current or last granted producer
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  input  logic                        fifo_alm_full,
  output logic                        fifo_wren,
  output logic [DATA_W-1:0]           fifo_wdata,
  output logic                        grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int ID_W  = grant_id_width(NUM_REQ);
  localparam int CNT_W = beat_cnt_width(MAX_BURST);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               wren_q;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic               pick_vld;
  logic [ID_W-1:0]    pick_id;
  logic               slot_open;
  logic               cur_valid;
  logic               accept;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .pick_vld_o   (pick_vld),
    .pick_id_o    (pick_id)
  );

  // Ready is gated by almost-full as well as full so that a beat already in
  // the output register always finds room in the FIFO.
  assign slot_open = (state_q == BURST) && !fifo_alm_full && !fifo_full;
  assign cur_valid = req_valid[grant_id_q];
  assign accept    = slot_open && cur_valid;

  always_comb begin
    req_ready             = '0;
    req_ready[grant_id_q] = slot_open;
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        // Arbitration cycle: never accepts a beat.
        if (pick_vld) begin
          state_d      = BURST;
          grant_id_d   = pick_id;
          last_grant_d = pick_id;
          beat_cnt_d   = '0;
        end
      end
      BURST: begin
        // A valid drop ends the grant even while stalled on the FIFO flags.
        if (!cur_valid) begin
          state_d = IDLE;
        end else if (accept) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wdata_d = accept ? data_arr[grant_id_q] : wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_ID;   // producer 0 wins the first arbitration
      beat_cnt_q   <= '0;
      wren_q       <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      wren_q       <= accept;
      wdata_q      <= wdata_d;
    end
  end

  assign fifo_wren  = wren_q;
  assign fifo_wdata = wdata_q;
  assign grant_vld  = (state_q == BURST);
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Two arbiter instances (MAX_BURST 8 and 2) share one set of producer/FIFO
// stimulus. A behavioural model per instance predicts every output on every
// cycle; directed phases add literal expectations for burst shapes, grant
// order, stalls, valid drops and reset.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int NM = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic              fifo_full = 1'b0;
  logic              fifo_alm_full = 1'b0;

  logic [N-1:0]      ready_a, ready_b;
  logic              wren_a, wren_b;
  logic [DW-1:0]     wdata_a, wdata_b;
  logic              gv_a, gv_b;
  logic [1:0]        gid_a, gid_b;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(8)) dut_a (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_a), .fifo_full(fifo_full), .fifo_alm_full(fifo_alm_full),
    .fifo_wren(wren_a), .fifo_wdata(wdata_a), .grant_vld(gv_a), .grant_id(gid_a)
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(2)) dut_b (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_b), .fifo_full(fifo_full), .fifo_alm_full(fifo_alm_full),
    .fifo_wren(wren_b), .fifo_wdata(wdata_b), .grant_vld(gv_b), .grant_id(gid_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            max_burst [NM] = '{8, 2};
  bit            m_burst   [NM] = '{0, 0};
  int            m_gid     [NM] = '{0, 0};
  int            m_last    [NM] = '{N-1, N-1};
  int            m_cnt     [NM] = '{0, 0};
  bit            m_wren    [NM] = '{0, 0};
  logic [DW-1:0] m_wdata   [NM] = '{default: '0};

  bit  acc_flag = 1'b0;   // instance A accepts at the coming posedge
  int  acc_id   = 0;

  logic [DW-1:0] log_a[$];
  logic [DW-1:0] log_b[$];
  bit            trace_a[$];

  task automatic model_reset(input int m);
    m_burst[m] = 1'b0; m_gid[m] = 0; m_last[m] = N-1;
    m_cnt[m] = 0; m_wren[m] = 1'b0; m_wdata[m] = '0;
  endtask

  // Outputs are compared at the falling edge; the model is then advanced to
  // the state it must hold after the next rising edge (inputs change only
  // just after rising edges, so what is seen here is what that edge samples).
  initial begin
    logic [N-1:0]  o_ready, exp_ready;
    logic          o_wren, o_gv, acc, found;
    logic [DW-1:0] o_wdata;
    logic [1:0]    o_gid;
    forever begin
      @(negedge clk);
      for (int m = 0; m < NM; m++) begin
        if (m == 0) begin
          o_ready = ready_a; o_wren = wren_a; o_wdata = wdata_a; o_gv = gv_a; o_gid = gid_a;
          trace_a.push_back(wren_a);
          if (wren_a) log_a.push_back(wdata_a);
        end else begin
          o_ready = ready_b; o_wren = wren_b; o_wdata = wdata_b; o_gv = gv_b; o_gid = gid_b;
          if (wren_b) log_b.push_back(wdata_b);
        end
        if (!rst_n) model_reset(m);
        exp_ready = '0;
        if (m_burst[m] && !fifo_alm_full && !fifo_full) exp_ready[m_gid[m]] = 1'b1;
        check($sformatf("m%0d_req_ready", m), o_ready, exp_ready);
        check($sformatf("m%0d_fifo_wren", m), o_wren, m_wren[m]);
        check($sformatf("m%0d_fifo_wdata", m), o_wdata, m_wdata[m]);
        check($sformatf("m%0d_grant_vld", m), o_gv, m_burst[m]);
        check($sformatf("m%0d_grant_id", m), o_gid, m_gid[m]);

        acc = 1'b0;
        if (rst_n) begin
          acc = m_burst[m] && req_valid[m_gid[m]] && !fifo_alm_full && !fifo_full;
          if (m == 0) acc_id = m_gid[m];
          m_wren[m] = acc;
          if (acc) m_wdata[m] = req_data[m_gid[m]*DW +: DW];
          if (!m_burst[m]) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
              if (!found && req_valid[(m_last[m] + k) % N]) begin
                found = 1'b1;
                m_gid[m]  = (m_last[m] + k) % N;
                m_last[m] = m_gid[m];
                m_cnt[m]  = 0;
                m_burst[m] = 1'b1;
              end
            end
          end else if (!req_valid[m_gid[m]]) begin
            m_burst[m] = 1'b0;
          end else if (acc) begin
            m_cnt[m]++;
            if (m_cnt[m] == max_burst[m]) m_burst[m] = 1'b0;
          end
        end
        if (m == 0) acc_flag = acc;
      end
    end
  end

  // ---------------- stimulus ----------------
  int          ctr   [N];
  int          limit [N];
  logic [31:0] salt  [N];
  bit          rand_mode = 1'b0;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rand_mode) begin
        req_valid[i] = ($urandom_range(0, 9) != 0);
        req_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        req_valid[i] = (ctr[i] < limit[i]);
        req_data[i*DW +: DW] = {8'(i), 56'd0, salt[i], 32'(ctr[i])};
      end
    end
  endtask

  // One clock: producers advance on instance A's accepts, then inputs are
  // re-driven. Returns 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (acc_flag) begin
      ctr[acc_id]++;
      salt[acc_id] = $urandom;
    end
    drive();
    #1;
  endtask

  task automatic clear_stream();
    for (int i = 0; i < N; i++) begin
      ctr[i] = 0; limit[i] = 0; salt[i] = $urandom;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    clear_stream();
    log_a.delete(); log_b.delete(); trace_a.delete();
  endtask

  task automatic wait_ctr(input int i, input int target, input int budget, input string name);
    int n = 0;
    while (ctr[i] < target && n < budget) begin
      step();
      n++;
    end
    check(name, (ctr[i] >= target), 1'b1);
  endtask

  int runs_q[$];
  int gaps_q[$];

  task automatic compute_runs();
    int  run = 0;
    int  gap = 0;
    bit  seen = 1'b0;
    runs_q.delete(); gaps_q.delete();
    foreach (trace_a[j]) begin
      if (trace_a[j]) begin
        if (run == 0 && seen) gaps_q.push_back(gap);
        run++; gap = 0;
      end else begin
        if (run > 0) begin runs_q.push_back(run); run = 0; seen = 1'b1; end
        gap++;
      end
    end
    if (run > 0) runs_q.push_back(run);
  endtask

  function automatic int q_at(input int idx, input int sel);
    if (sel == 0) return (idx < runs_q.size()) ? runs_q[idx] : -1;
    return (idx < gaps_q.size()) ? gaps_q[idx] : -1;
  endfunction

  initial begin
    int   exp_runs_a [3] = '{8, 8, 4};
    int   exp_tags_b [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int   bad;
    logic [7:0] tag;
    clear_stream();

    // Reset state
    step(); step();
    check("rst_fifo_wren", wren_a, 1'b0);
    check("rst_fifo_wdata", wdata_a, '0);
    check("rst_grant_vld", gv_a, 1'b0);
    check("rst_grant_id", gid_a, 2'd0);
    check("rst_req_ready", ready_a, 4'b0000);
    rst_n = 1'b1;

    // Single producer, 20 beats, MAX_BURST 8: bursts 8/8/4, one bubble each
    do_reset();
    limit[0] = 20;
    wait_ctr(0, 20, 200, "A_timeout");
    repeat (4) step();
    check("A_write_count", log_a.size(), 20);
    bad = 0;
    foreach (log_a[j]) if (log_a[j][31:0] != 32'(j) || log_a[j][127:120] != 8'd0) bad++;
    check("A_data_order_bad", bad, 0);
    compute_runs();
    check("A_num_runs", runs_q.size(), 3);
    for (int j = 0; j < 3; j++) check($sformatf("A_run%0d", j), q_at(j, 0), exp_runs_a[j]);
    for (int j = 0; j < 2; j++) check($sformatf("A_gap%0d", j), q_at(j, 1), 1);

    // All four producers valid: grant order 0,1,2,3
    do_reset();
    for (int i = 0; i < N; i++) limit[i] = 1000;
    repeat (50) step();
    for (int i = 0; i < N; i++) limit[i] = 0;
    repeat (4) step();
    for (int j = 0; j < 8; j++) begin
      tag = (j < log_b.size()) ? log_b[j][127:120] : 8'hff;
      check($sformatf("B_mb2_tag%0d", j), tag, exp_tags_b[j]);
    end
    bad = 0;
    for (int j = 0; j < 32; j++) begin
      tag = (j < log_a.size()) ? log_a[j][127:120] : 8'hff;
      if (tag != 8'(j / 8)) bad++;
    end
    check("B_mb8_tag_bad", bad, 0);

    // Almost-full held for 5 cycles after the 3rd beat of an 8-beat burst
    do_reset();
    limit[1] = 8;
    wait_ctr(1, 3, 50, "C_timeout_pre");
    fifo_alm_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      check($sformatf("C_stall%0d_ready", s), ready_a, 4'b0000);
      check($sformatf("C_stall%0d_wren", s), wren_a, 1'b0);
      check($sformatf("C_stall%0d_gvld", s), gv_a, 1'b1);
    end
    fifo_alm_full = 1'b0;
    wait_ctr(1, 8, 50, "C_timeout_post");
    repeat (4) step();
    check("C_write_count", log_a.size(), 8);
    bad = 0;
    foreach (log_a[j]) if (log_a[j][31:0] != 32'(j) || log_a[j][127:120] != 8'd1) bad++;
    check("C_data_order_bad", bad, 0);
    compute_runs();
    check("C_run0", q_at(0, 0), 3);
    check("C_run1", q_at(1, 0), 5);
    check("C_gap0", q_at(0, 1), 5);
    check("C_num_runs", runs_q.size(), 2);

    // Producer 2 drops valid after 3 beats while producer 3 waits
    do_reset();
    limit[2] = 3;
    limit[3] = 100;
    wait_ctr(2, 3, 50, "D_timeout");
    check("D_still_granted", gid_a, 2'd2);
    step();
    check("D_idle_gvld", gv_a, 1'b0);
    step();
    check("D_next_gvld", gv_a, 1'b1);
    check("D_next_gid", gid_a, 2'd3);
    limit[3] = 0;
    repeat (6) step();

    // Reset asserted for two cycles in the middle of producer 2's burst
    do_reset();
    limit[0] = 1000;
    limit[2] = 1000;
    wait_ctr(2, 2, 100, "E_timeout");
    rst_n = 1'b0;
    #1;
    check("E_wren_drop", wren_a, 1'b0);
    check("E_wdata_rst", wdata_a, '0);
    check("E_gvld_rst", gv_a, 1'b0);
    check("E_gid_rst", gid_a, 2'd0);
    check("E_ready_rst", ready_a, 4'b0000);
    step(); step();
    rst_n = 1'b1;
    for (int n = 0; n < 10 && !gv_a; n++) step();
    check("E_regrant_vld", gv_a, 1'b1);
    check("E_regrant_id", gid_a, 2'd0);

    // Randomized traffic with FIFO flag pulses and occasional resets
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      fifo_alm_full = ($urandom_range(0, 7) == 0);
      fifo_full     = ($urandom_range(0, 15) == 0);
      rst_n         = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
